// File: rtl/alu_pkg.sv
// Shared aluControl encodings and muldiv FSM state encoding used by the
// execute-stage units.
package alu_pkg;

  localparam logic [5:0] OP_MUL    = 6'b100111;
  localparam logic [5:0] OP_MULH   = 6'b101000;
  localparam logic [5:0] OP_MULHU  = 6'b101001;
  localparam logic [5:0] OP_MULHSU = 6'b101010;
  localparam logic [5:0] OP_DIV    = 6'b101011;
  localparam logic [5:0] OP_DIVU   = 6'b101100;
  localparam logic [5:0] OP_REM    = 6'b101101;
  localparam logic [5:0] OP_REMU   = 6'b101110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 iteration datapath: hi:lo holds product (multiply) or
// remainder:quotient (divide); opnd holds multiplicand or divisor.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            clear,
  input  logic            is_div,
  input  logic [XLEN-1:0] opnd_init,
  input  logic [XLEN-1:0] lo_init,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt,
  output logic            last
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opnd;
  logic [5:0]      count;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // The remainder stays below the divisor, so bit XLEN of diff is a clean borrow flag.
  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    hi_nxt  = '0;
    lo_nxt  = '0;
    if (is_div) begin
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = add_sum[XLEN:1];
      lo_nxt = {add_sum[0], lo[XLEN-1:1]};
    end
  end

  assign last = (count == 6'd31);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      count <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= lo_init;
      opnd  <= opnd_init;
      count <= '0;
    end else if (step) begin
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      count <= count + 6'd1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32 M-extension iterative multiply/divide unit: FSM, operand sign
// handling, divide special cases and result selection around muldiv_core.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_e   state;
  logic [5:0]      op_q;
  logic            sign_q;
  logic            sign_r;

  logic            accept, signed_a, signed_b, neg_a, neg_b;
  logic            div_op, div_zero, ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_val;
  logic [XLEN-1:0] hi_nxt, lo_nxt;
  logic            last;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, final_val;

  always_comb begin
    accept   = (state == ST_IDLE) && start && !kill && is_muldiv(op);
    signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg_a    = signed_a && a[XLEN-1];
    neg_b    = signed_b && b[XLEN-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    div_op   = (op >= OP_DIV);
    div_zero = div_op && (b == '0);
    ovf      = div_op && signed_b && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = div_zero || ovf;
    special_val = '0;
    if (div_zero)
      special_val = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
    else if (ovf)
      special_val = (op == OP_DIV) ? a : '0;
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept && !special),
    .step      ((state == ST_CALC) && !kill),
    .clear     (kill),
    .is_div    (op_q >= OP_DIV),
    .opnd_init (div_op ? mag_b : mag_a),
    .lo_init   (div_op ? mag_a : mag_b),
    .hi_nxt    (hi_nxt),
    .lo_nxt    (lo_nxt),
    .last      (last)
  );

  // Sign correction is applied to the final iteration's combinational output.
  always_comb begin
    prod     = {hi_nxt, lo_nxt};
    prod_fix = sign_q ? -prod : prod;
    quot_fix = sign_q ? -lo_nxt : lo_nxt;
    rem_fix  = sign_r ? -hi_nxt : hi_nxt;
    case (op_q)
      OP_MUL:                       final_val = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU: final_val = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_val = quot_fix;
      OP_REM, OP_REMU:              final_val = rem_fix;
      default:                      final_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (kill) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            op_q   <= op;
            sign_q <= neg_a ^ neg_b;
            sign_r <= neg_a;
            busy   <= 1'b1;
            if (special) begin
              result <= special_val;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (last) begin
            result <= final_val;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit: expected results are queued
// at start and compared when done pulses.
module tb_muldiv_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_want = '0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [5:0] f_op, input logic [31:0] x,
                                             input logic [31:0] y);
    logic [63:0] xs, xu, ys, yu, p;
    logic [31:0] r;
    xs = {{32{x[31]}}, x};
    xu = {32'b0, x};
    ys = {{32{y[31]}}, y};
    yu = {32'b0, y};
    r  = '0;
    case (f_op)
      OP_MUL:    begin p = xu * yu; r = p[31:0];  end
      OP_MULH:   begin p = xs * ys; r = p[63:32]; end
      OP_MULHU:  begin p = xu * yu; r = p[63:32]; end
      OP_MULHSU: begin p = xs * yu; r = p[63:32]; end
      OP_DIV: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(x) / $signed(y);
      end
      OP_REM: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
        else r = $signed(x) % $signed(y);
      end
      OP_DIVU: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REMU: r = (y == 0) ? x : x % y;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_special(input logic [5:0] f_op, input logic [31:0] x,
                                      input logic [31:0] y);
    return (f_op >= OP_DIV) && ((y == 0) ||
           ((f_op == OP_DIV || f_op == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // edges = rising edges after the start edge before done is seen (0 for special cases).
  task automatic run_op(input string tag, input logic [5:0] t_op, input logic [31:0] x,
                        input logic [31:0] y);
    int edges;
    int busy_cnt;
    int exp_lat;
    logic [31:0] want;
    exp_lat = is_special(t_op, x, y) ? 0 : 32;
    @(negedge clk);
    start = 1'b1; op = t_op; a = x; b = y;
    exp_q.push_back(ref_result(t_op, x, y));
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
    if (busy) busy_cnt++;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    want = exp_q.pop_front();
    check({tag, "_result"}, result, want);
    last_want = want;
    @(negedge clk);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat + 1));
    check({tag, "_idle_after"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int   done_seen;
    int   busy_seen;
    logic [5:0]  r_op;
    logic [31:0] r_a, r_b;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;

    run_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD);
    check("mul_7_m3_const", last_want, 32'hFFFF_FFEB);
    run_op("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000);
    check("mulh_min_const", last_want, 32'h4000_0000);
    run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_max_const", last_want, 32'hFFFF_FFFE);
    run_op("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhsu_m1_const", last_want, 32'hFFFF_FFFF);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_const", last_want, 32'hFFFF_FFFD);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
    check("rem_m7_2_const", last_want, 32'hFFFF_FFFF);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    check("divu_100_7_const", last_want, 32'd14);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7);
    check("remu_100_7_const", last_want, 32'd2);
    run_op("div_by0", OP_DIV, 32'd5, 32'd0);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0);
    check("remu_by0_const", last_want, 32'd5);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_pre_kill", OP_DIVU, 32'd100, 32'd7);

    // kill ten cycles into a DIV
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_done", 32'(done), 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("kill_no_done", 32'(done_seen), 32'd0);
    check("kill_result_held", result, last_want);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd10;
    exp_q.push_back(ref_result(OP_DIVU, 32'd1000, 32'd10));
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    repeat (40) begin
      if (done) done_seen++;
      if (done) last_want = exp_q.pop_front();
      if (done) check("busy_start_result", result, last_want);
      @(negedge clk);
    end
    check("busy_start_one_done", 32'(done_seen), 32'd1);
    check("busy_start_not_queued", 32'(busy), 32'd0);

    // invalid op
    @(negedge clk);
    start = 1'b1; op = 6'b000010; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    busy_seen = 0;
    repeat (4) begin
      if (busy || done) busy_seen++;
      @(negedge clk);
    end
    check("invalid_op_ignored", 32'(busy_seen), 32'd0);

    // kill and start together
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = OP_MUL; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    busy_seen = 0;
    repeat (40) begin
      if (busy || done) busy_seen++;
      @(negedge clk);
    end
    check("kill_start_same", 32'(busy_seen), 32'd0);
    check("kill_start_result", result, last_want);

    // reset mid multiply
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", result, 32'd0);
    rst_n = 1'b1;
    run_op("mul_3_4", OP_MUL, 32'd3, 32'd4);
    check("mul_3_4_const", last_want, 32'd12);

    for (int i = 0; i < 10; i++) begin
      r_op = 6'(OP_MUL + 6'($urandom_range(0, 7)));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op("rand", r_op, r_a, r_b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide execution unit for the RV32 M-extension ops. It sits directly downstream of control_unit and consumes its 6-bit aluControl codes 100111..101110 (MUL..REMU), alongside the execute-stage ALU. It accepts one operation per start pulse, holds busy while computing, and returns a registered 32-bit result with a one-cycle done pulse so the pipeline can stall around it.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  synchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  6  aluControl code from control_unit
a  in  XLEN  rs1 operand (dividend / multiplicand)
b  in  XLEN  rs2 operand (divisor / multiplier)
kill  in  1  synchronous abort (pipeline flush)
busy  out  1  high while in CALC or DONE
done  out  1  one-cycle pulse; result valid this cycle
result  out  XLEN  registered result, held until the next completion

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, result=0; counter and working registers cleared. Reset mid-operation abandons the op, and no done is produced.
- States: IDLE, CALC, DONE.
- IDLE: at edge E0 with start=1, kill=0 and op in the muldiv set, capture a, b and op, and go to CALC. Otherwise stay in IDLE. A start with an op outside the set is ignored: no busy, no done.
- Operand prep at E0: convert signed operands to magnitudes and record the result sign.
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MUL: treated as unsigned (the low word is identical).
  - DIV/REM: both operands signed.
  - MULHU/DIVU/REMU: both operands unsigned.
- Special cases, detected at E0: go straight to DONE, so done is visible in the cycle after E0.
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: a 6-bit counter runs 0..31, with one radix-2 iteration per edge (E1..E32).
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring shift-subtract, 32-bit quotient and remainder.
- At E32: apply sign correction.
  - Product: two's-complement negate the 64-bit value.
  - Quotient: sign = sign_a ^ sign_b.
  - Remainder: sign = sign_a.
  - Select the output word: MUL takes the low 32 bits; MULH/MULHU/MULHSU take the high 32 bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Write result and go to DONE.
- Latency: done is high in the cycle following E32, i.e. 32 cycles after the start edge (1 cycle for special cases).
- DONE: done=1 and busy=1 for exactly one cycle; the next edge returns to IDLE. A new start can be accepted at the edge that leaves DONE? No: start is sampled only in IDLE, so throughput is one op per 34 cycles.
- start while busy: ignored, with no queuing.
- kill: at any edge with kill=1, go to IDLE with busy=0 next cycle and no done. result keeps its previous value. kill and start in the same IDLE cycle: kill wins and the op is not accepted.
- kill in DONE: done is already visible in that cycle, and the state still returns to IDLE.
- All arithmetic is modulo 2^XLEN (2^64 for the product); no exceptions are raised.

Decomposition:
- Shared package (alu_pkg): the 6-bit aluControl localparams for the full set, including OP_MUL=100111, OP_MULH=101000, OP_MULHU=101001, OP_MULHSU=101010, OP_DIV=101011, OP_DIVU=101100, OP_REM=101101, OP_REMU=101110. The package also holds the muldiv state encoding and the helper is_muldiv(op). control_unit is updated to use the same package.
- One natural sub-module: muldiv_core, the iteration datapath (product/remainder shift registers, adder/subtractor, counter). muldiv_unit keeps the FSM, sign handling, special cases and the result mux.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result=0xFFFFFFEB; done exactly 32 cycles after the start edge; busy high for 33 cycles.
- MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU on the same operands -> 2.
- Special cases: DIV a=5, b=0 -> 0xFFFFFFFF and REMU a=5, b=0 -> 5, each with done 1 cycle after start. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 and REM -> 0, also 1 cycle.
- kill asserted 10 cycles into a DIV -> busy low next cycle, done never pulses, result unchanged. start asserted while busy -> ignored. Invalid op (000010) with start -> busy stays 0.
- rst_n low mid-MUL (cycle 15) -> busy=0, done=0, result=0 next cycle. A fresh MUL 3*4 then returns 12 after 32 cycles.
